// File: rtl/id_ex_if.sv
// Bundle of the ID/EX stage boundary: decoded ID fields, MEM/WB bypass sources,
// and everything the stage presents to the ALU and the MEM stage.
interface id_ex_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               id_valid;
  logic [RADDR_W-1:0] id_rs_addr;
  logic [RADDR_W-1:0] id_rt_addr;
  logic [RADDR_W-1:0] id_rd_addr;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [15:0]        id_imm16;
  logic [4:0]         id_shamt;
  logic [3:0]         id_alu_op;
  logic               id_alu_src;
  logic               id_sign_ext;
  logic               id_reg_dst;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               flush;
  logic               mem_reg_write;
  logic [RADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0]  mem_result;
  logic               wb_reg_write;
  logic [RADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0]  wb_data;

  logic               load_use_stall;
  logic               ex_valid;
  logic [3:0]         aluControlOp;
  logic               aluSrc;
  logic [DATA_W-1:0]  rsData;
  logic [DATA_W-1:0]  rtData;
  logic [4:0]         shamt;
  logic [DATA_W-1:0]  imm;
  logic [RADDR_W-1:0] ex_dest;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm16, id_shamt, id_alu_op, id_alu_src, id_sign_ext, id_reg_dst,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_reg_write, mem_dest, mem_result, wb_reg_write, wb_dest, wb_data,
    output load_use_stall, ex_valid, aluControlOp, aluSrc, rsData, rtData,
           shamt, imm, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm16, id_shamt, id_alu_op, id_alu_src, id_sign_ext, id_reg_dst,
           id_reg_write, id_mem_read, id_mem_write, flush,
           mem_reg_write, mem_dest, mem_result, wb_reg_write, wb_dest, wb_data,
    input  load_use_stall, ex_valid, aluControlOp, aluSrc, rsData, rtData,
           shamt, imm, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, immediate extension,
// register-file write-through at capture and MEM/WB operand forwarding.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [4:0]         shamt;
    logic [3:0]         alu_op;
    logic               alu_src;
    logic [RADDR_W-1:0] dest;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } ex_regs_t;

  ex_regs_t          r_ex;
  ex_regs_t          w_capture;
  ex_regs_t          w_next;
  logic              w_stall;
  logic              w_wb_hits_rs, w_wb_hits_rt;
  logic              w_fwd_mem_rs, w_fwd_mem_rt, w_fwd_wb_rs, w_fwd_wb_rt;
  logic [DATA_W-1:0] w_rs_fwd, w_rt_fwd;

  // Both sources are compared even when the instruction does not read rt.
  assign w_stall = r_ex.valid & r_ex.mem_read & (r_ex.dest != '0) &
                   ((r_ex.dest == bus.id_rs_addr) | (r_ex.dest == bus.id_rt_addr)) &
                   bus.id_valid;

  // Register file is written in the same cycle it is read; bypass that write here.
  assign w_wb_hits_rs = bus.wb_reg_write & (bus.wb_dest != '0) & (bus.wb_dest == bus.id_rs_addr);
  assign w_wb_hits_rt = bus.wb_reg_write & (bus.wb_dest != '0) & (bus.wb_dest == bus.id_rt_addr);

  always_comb begin
    w_capture           = '0;
    w_capture.valid     = bus.id_valid;
    w_capture.rs_addr   = bus.id_rs_addr;
    w_capture.rt_addr   = bus.id_rt_addr;
    w_capture.rs_data   = w_wb_hits_rs ? bus.wb_data : bus.id_rs_data;
    w_capture.rt_data   = w_wb_hits_rt ? bus.wb_data : bus.id_rt_data;
    w_capture.imm       = bus.id_sign_ext ? {{(DATA_W-16){bus.id_imm16[15]}}, bus.id_imm16}
                                          : {{(DATA_W-16){1'b0}}, bus.id_imm16};
    w_capture.shamt     = bus.id_shamt;
    w_capture.alu_op    = bus.id_alu_op;
    w_capture.alu_src   = bus.id_alu_src;
    w_capture.dest      = bus.id_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;
    w_capture.reg_write = bus.id_reg_write & bus.id_valid;
    w_capture.mem_read  = bus.id_mem_read  & bus.id_valid;
    w_capture.mem_write = bus.id_mem_write & bus.id_valid;
  end

  // Flush and load-use both squash to an all-zero bubble; flush needs no separate priority.
  assign w_next = (bus.flush | w_stall) ? '0 : w_capture;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values; the stage holds only flops, so all are reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ex <= '0;
    else     r_ex <= w_next;
  end

  assign w_fwd_mem_rs = bus.mem_reg_write & (bus.mem_dest != '0) & (bus.mem_dest == r_ex.rs_addr);
  assign w_fwd_mem_rt = bus.mem_reg_write & (bus.mem_dest != '0) & (bus.mem_dest == r_ex.rt_addr);
  assign w_fwd_wb_rs  = bus.wb_reg_write  & (bus.wb_dest  != '0) & (bus.wb_dest  == r_ex.rs_addr);
  assign w_fwd_wb_rt  = bus.wb_reg_write  & (bus.wb_dest  != '0) & (bus.wb_dest  == r_ex.rt_addr);

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    w_rs_fwd = r_ex.rs_data;
    w_rt_fwd = r_ex.rt_data;
    if (w_fwd_mem_rs)     w_rs_fwd = bus.mem_result;
    else if (w_fwd_wb_rs) w_rs_fwd = bus.wb_data;
    if (w_fwd_mem_rt)     w_rt_fwd = bus.mem_result;
    else if (w_fwd_wb_rt) w_rt_fwd = bus.wb_data;
  end

  assign bus.load_use_stall = w_stall;
  assign bus.ex_valid       = r_ex.valid;
  assign bus.aluControlOp   = r_ex.alu_op;
  assign bus.aluSrc         = r_ex.alu_src;
  assign bus.rsData         = w_rs_fwd;
  assign bus.rtData         = w_rt_fwd;
  assign bus.shamt          = r_ex.shamt;
  assign bus.imm            = r_ex.imm;
  assign bus.ex_dest        = r_ex.dest;
  assign bus.ex_reg_write   = r_ex.reg_write;
  assign bus.ex_mem_read    = r_ex.mem_read;
  assign bus.ex_mem_write   = r_ex.mem_write;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// checked against an instruction-level model of what EX should hold.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(32), .RADDR_W(5)) bus ();
  id_ex_stage #(.DATA_W(32), .RADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // What the EX stage holds, in instruction terms.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt;
    logic [3:0]  op;
    logic        src;
    logic [4:0]  dest;
    logic        rw, mr, mw;
  } instr_t;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic        src;
    logic [31:0] rs, rt;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        rw, mr, mw;
  } obs_t;

  instr_t m_ex = '0;

  // Register-file read as seen by ID: the same-cycle WB write is visible, r0 never changes.
  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic [31:0] raw);
    if (a != 0 && bus.wb_reg_write && bus.wb_dest == a) return bus.wb_data;
    return raw;
  endfunction

  // Newest producer wins: MEM is younger than WB; r0 is a constant zero register.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] held);
    if (a == 0) return held;
    if (bus.mem_reg_write && bus.mem_dest == a) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_dest == a) return bus.wb_data;
    return held;
  endfunction

  function automatic logic model_stall();
    return m_ex.valid && m_ex.mr && m_ex.dest != 0 && bus.id_valid &&
           (m_ex.dest == bus.id_rs_addr || m_ex.dest == bus.id_rt_addr);
  endfunction

  function automatic instr_t model_decode();
    instr_t c;
    c.valid  = bus.id_valid;
    c.rs     = bus.id_rs_addr;
    c.rt     = bus.id_rt_addr;
    c.rs_val = rf_read(bus.id_rs_addr, bus.id_rs_data);
    c.rt_val = rf_read(bus.id_rt_addr, bus.id_rt_data);
    c.imm    = bus.id_sign_ext ? 32'($signed(bus.id_imm16)) : 32'(bus.id_imm16);
    c.shamt  = bus.id_shamt;
    c.op     = bus.id_alu_op;
    c.src    = bus.id_alu_src;
    c.dest   = bus.id_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;
    c.rw     = bus.id_valid && bus.id_reg_write;
    c.mr     = bus.id_valid && bus.id_mem_read;
    c.mw     = bus.id_valid && bus.id_mem_write;
    return c;
  endfunction

  function automatic obs_t expected();
    obs_t e;
    e.v = m_ex.valid; e.op = m_ex.op; e.src = m_ex.src;
    e.rs = operand(m_ex.rs, m_ex.rs_val);
    e.rt = operand(m_ex.rt, m_ex.rt_val);
    e.sh = m_ex.shamt; e.imm = m_ex.imm; e.dest = m_ex.dest;
    e.rw = m_ex.rw; e.mr = m_ex.mr; e.mw = m_ex.mw;
    return e;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.v = bus.ex_valid; o.op = bus.aluControlOp; o.src = bus.aluSrc;
    o.rs = bus.rsData; o.rt = bus.rtData; o.sh = bus.shamt; o.imm = bus.imm;
    o.dest = bus.ex_dest; o.rw = bus.ex_reg_write; o.mr = bus.ex_mem_read;
    o.mw = bus.ex_mem_write;
    return o;
  endfunction

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm16 = 0; bus.id_shamt = 0;
    bus.id_alu_op = 0; bus.id_alu_src = 0; bus.id_sign_ext = 0; bus.id_reg_dst = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.flush = 0;
    bus.mem_reg_write = 0; bus.mem_dest = 0; bus.mem_result = 0;
    bus.wb_reg_write = 0; bus.wb_dest = 0; bus.wb_data = 0;
  endtask

  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic reg_dst, input logic rw, input logic mr);
    bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_rd_addr = rd;
    bus.id_reg_dst = reg_dst; bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_mem_write = 0;
  endtask

  // One clock edge for both DUT and model; returns at posedge + 1.
  task automatic tick();
    m_ex = (bus.flush || model_stall()) ? '0 : model_decode();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    clear_inputs();
    rst = 1; #12; rst = 0; m_ex = '0;
    @(negedge clk);
    checks++;
    o = observed();
    if (o !== obs_t'('0) || bus.load_use_stall !== 1'b0) begin
      errors++; $display("FAIL reset_state got %h stall %b want all zero", o, bus.load_use_stall);
    end
    id_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
    bus.id_imm16 = 16'h1234; bus.id_alu_op = 4'd2;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1 || bus.imm !== 32'h1234) begin
      errors++; $display("FAIL reset_preload got v=%b rw=%b imm=%h want 1 1 00001234",
                         bus.ex_valid, bus.ex_reg_write, bus.imm);
    end
    #2 rst = 1; #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.imm !== 32'h0) begin
      errors++; $display("FAIL reset_async got v=%b rw=%b imm=%h want 0 0 0",
                         bus.ex_valid, bus.ex_reg_write, bus.imm);
    end
    m_ex = '0;
    #2 rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_imm_ext();
    id_instr(5'd4, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
    bus.id_imm16 = 16'h8001; bus.id_sign_ext = 1; bus.id_alu_src = 1;
    tick();
    checks++;
    if (bus.imm !== 32'hFFFF8001 || bus.aluSrc !== 1'b1 || bus.ex_dest !== 5'd6) begin
      errors++; $display("FAIL imm_sign got imm=%h src=%b dest=%0d want FFFF8001 1 6",
                         bus.imm, bus.aluSrc, bus.ex_dest);
    end
    bus.id_sign_ext = 0;
    tick();
    checks++;
    if (bus.imm !== 32'h00008001) begin
      errors++; $display("FAIL imm_zero got %h want 00008001", bus.imm);
    end
    clear_inputs();
  endtask

  task automatic test_forward();
    id_instr(5'd5, 5'd7, 5'd9, 1'b1, 1'b1, 1'b0);
    bus.id_rs_data = 32'h1111;
    tick();
    bus.id_valid = 0;
    bus.mem_reg_write = 1; bus.mem_dest = 5; bus.mem_result = 32'hA;
    bus.wb_reg_write = 1;  bus.wb_dest = 5;  bus.wb_data = 32'hB;
    #1;
    checks++;
    if (bus.rsData !== 32'hA) begin
      errors++; $display("FAIL fwd_mem_over_wb got %h want 0000000a", bus.rsData);
    end
    bus.mem_reg_write = 0; #1;
    checks++;
    if (bus.rsData !== 32'hB) begin
      errors++; $display("FAIL fwd_wb got %h want 0000000b", bus.rsData);
    end
    bus.wb_reg_write = 0; #1;
    checks++;
    if (bus.rsData !== 32'h1111) begin
      errors++; $display("FAIL fwd_none got %h want 00001111", bus.rsData);
    end
    clear_inputs();
  endtask

  task automatic test_reg0();
    id_instr(5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    bus.id_valid = 0;
    bus.mem_reg_write = 1; bus.mem_dest = 0; bus.mem_result = 32'hDEAD; #1;
    checks++;
    if (bus.rtData !== 32'h0) begin
      errors++; $display("FAIL reg0_fwd got %h want 00000000", bus.rtData);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    id_instr(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    id_instr(5'd2, 5'd8, 5'd10, 1'b1, 1'b1, 1'b0); #1;
    checks++;
    if (bus.load_use_stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall got %b want 1", bus.load_use_stall);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.load_use_stall !== 1'b0) begin
      errors++; $display("FAIL lu_bubble got v=%b stall=%b want 0 0", bus.ex_valid, bus.load_use_stall);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd10 || bus.ex_reg_write !== 1'b1) begin
      errors++; $display("FAIL lu_resume got v=%b dest=%0d rw=%b want 1 10 1",
                         bus.ex_valid, bus.ex_dest, bus.ex_reg_write);
    end
    clear_inputs();
  endtask

  task automatic test_flush_and_writethrough();
    id_instr(5'd1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
    tick();
    id_instr(5'd8, 5'd2, 5'd11, 1'b1, 1'b1, 1'b0);
    bus.flush = 1; #1;
    checks++;
    if (bus.load_use_stall !== 1'b1) begin
      errors++; $display("FAIL flush_stall got %b want 1", bus.load_use_stall);
    end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL flush_bubble got v=%b want 0", bus.ex_valid);
    end
    bus.flush = 0;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd11) begin
      errors++; $display("FAIL flush_one_cycle got v=%b dest=%0d want 1 11", bus.ex_valid, bus.ex_dest);
    end
    clear_inputs();
    id_instr(5'd3, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0);
    bus.id_rs_data = 32'h0;
    bus.wb_reg_write = 1; bus.wb_dest = 3; bus.wb_data = 32'h55;
    tick();
    bus.wb_reg_write = 0; bus.id_valid = 0; #1;
    checks++;
    if (bus.rsData !== 32'h55) begin
      errors++; $display("FAIL write_through got %h want 00000055", bus.rsData);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    obs_t e, o;
    logic s;
    for (int n = 0; n < 400; n++) begin
      bus.id_valid     = ($urandom_range(0, 7) != 0);
      bus.id_rs_addr   = 5'($urandom_range(0, 3));
      bus.id_rt_addr   = 5'($urandom_range(0, 3));
      bus.id_rd_addr   = 5'($urandom_range(0, 3));
      bus.id_rs_data   = $urandom;
      bus.id_rt_data   = $urandom;
      bus.id_imm16     = 16'($urandom);
      bus.id_shamt     = 5'($urandom);
      bus.id_alu_op    = 4'($urandom);
      bus.id_alu_src   = 1'($urandom);
      bus.id_sign_ext  = 1'($urandom);
      bus.id_reg_dst   = 1'($urandom);
      bus.id_reg_write = 1'($urandom);
      bus.id_mem_read  = ($urandom_range(0, 2) == 0);
      bus.id_mem_write = 1'($urandom);
      bus.flush        = ($urandom_range(0, 9) == 0);
      bus.wb_reg_write = 1'($urandom);
      bus.wb_dest      = 5'($urandom_range(0, 3));
      bus.wb_data      = $urandom;
      #1;
      s = model_stall();
      checks++;
      if (bus.load_use_stall !== s) begin
        errors++; $display("FAIL rand_stall[%0d] got %b want %b", n, bus.load_use_stall, s);
      end
      tick();
      bus.mem_reg_write = 1'($urandom);
      bus.mem_dest      = 5'($urandom_range(0, 3));
      bus.mem_result    = $urandom;
      bus.wb_reg_write  = 1'($urandom);
      bus.wb_dest       = 5'($urandom_range(0, 3));
      bus.wb_data       = $urandom;
      #1;
      e = expected();
      o = observed();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL rand_ex[%0d] got %h want %h", n, o, e);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_imm_ext();
    test_forward();
    test_reg0();
    test_load_use();
    test_flush_and_writethrough();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that feeds the ALU directly.
- Captures decoded fields from ID, inserts bubbles on flush or load-use hazard, and extends the 16-bit immediate.
- Presents forwarded rsData/rtData plus aluControlOp/aluSrc/shamt/imm to the ALU, and carries MEM/WB control onward.

Parameters:
DATA_W, 32, datapath width
RADDR_W, 5, register address width

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_rs_addr  input  RADDR_W  rs register number
id_rt_addr  input  RADDR_W  rt register number
id_rd_addr  input  RADDR_W  rd register number
id_rs_data  input  DATA_W  register-file rs read value
id_rt_data  input  DATA_W  register-file rt read value
id_imm16  input  16  instruction [15:0]
id_shamt  input  5  instruction [10:6]
id_alu_op  input  4  ALU control code (AND/OR/NOR/ADD/SUB/SLT/SLL/SRL encoding)
id_alu_src  input  1  1 = ALU B operand is imm
id_sign_ext  input  1  1 = sign-extend imm16, 0 = zero-extend
id_reg_dst  input  1  1 = dest is rd, 0 = dest is rt
id_reg_write  input  1  instruction writes a register
id_mem_read  input  1  instruction is a load
id_mem_write  input  1  instruction is a store
flush  input  1  squash instruction entering EX (taken branch/jump)
mem_reg_write  input  1  MEM-stage instruction writes a register
mem_dest  input  RADDR_W  MEM-stage destination
mem_result  input  DATA_W  MEM-stage ALU result
wb_reg_write  input  1  WB-stage instruction writes a register
wb_dest  input  RADDR_W  WB-stage destination
wb_data  input  DATA_W  WB-stage write data
load_use_stall  output  1  combinational; ID and IF must hold this cycle
ex_valid  output  1  EX holds a real instruction
aluControlOp  output  4  to ALU
aluSrc  output  1  to ALU
rsData  output  DATA_W  forwarded rs operand to ALU
rtData  output  DATA_W  forwarded rt operand to ALU (also store data)
shamt  output  5  to ALU
imm  output  DATA_W  extended immediate to ALU
ex_dest  output  RADDR_W  resolved destination register
ex_reg_write  output  1  control to MEM
ex_mem_read  output  1  control to MEM
ex_mem_write  output  1  control to MEM

Behaviour:
- Reset (async, rst=1): all registered fields cleared to 0, so EX holds a bubble. ex_valid, all ex_* controls, aluControlOp, aluSrc, shamt, imm and ex_dest are 0. rsData/rtData show forwarded values of the cleared registers.
- Latency: ID fields appear on outputs one cycle after the capturing clk edge.
- load_use_stall = ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs_addr | ex_dest==id_rt_addr) & id_valid.
  - Both sources are always compared (conservative).
- Capture priority per edge: flush > load_use_stall > normal capture.
  - flush or stall: load a bubble (all fields 0).
  - Normal: register the ID fields.
  - Controls are ANDed with id_valid: id_valid=0 captures reg_write/mem_read/mem_write = 0.
- ex_dest = id_reg_dst ? id_rd_addr : id_rt_addr, resolved at capture.
- imm = id_sign_ext ? {{16{id_imm16[15]}}, id_imm16} : {16'b0, id_imm16}, computed at capture.
- Register-file write-through at capture: if wb_reg_write & wb_dest!=0 & wb_dest==id_rs_addr, capture wb_data instead of id_rs_data. Same rule applies for rt.
- Forwarding (combinational on registered rs/rt address):
  - First choice: mem_result if mem_reg_write & mem_dest!=0 & match.
  - Else wb_data if wb_reg_write & wb_dest!=0 & match.
  - Else the registered value.
  - MEM wins over WB when both match.
- Register 0 is never captured-through or forwarded; it always yields the registered value (0 from the register file).
- rst asserted mid-operation clears EX immediately, independent of clk.

Test Plan:
- Reset: assert rst mid-cycle with a valid instruction in EX -> ex_valid=0, ex_reg_write=0, imm=0 immediately.
- Capture and extension: id_imm16=16'h8001 with sign_ext=1 -> imm=32'hFFFF8001 next cycle. With sign_ext=0 -> 32'h00008001.
- Forward priority: EX rs=5, mem_dest=5 (mem_result=32'hA), wb_dest=5 (wb_data=32'hB) -> rsData=32'hA. Drop mem_reg_write -> rsData=32'hB.
- Register 0: EX rt=0, mem_dest=0, mem_reg_write=1, mem_result=32'hDEAD -> rtData=0.
- Load-use: EX lw with dest 8, ID uses rt=8 -> load_use_stall=1, next cycle ex_valid=0. The following cycle the held instruction is captured.
- Flush beats stall, plus write-through:
  - flush=1 with load_use_stall=1 -> bubble, one cycle only.
  - Separately, wb_dest=3 with wb_data=32'h55 while ID rs=3 (id_rs_data=32'h0) -> rsData=32'h55 after capture, with WB deasserted.
